// File: rtl/nios_sdram_reset_sequencer_pkg.sv
// Shared types and constants for the SDRAM/system reset sequencer.
package nios_rst_seq_pkg;

  // Sequencer states; encodings are visible on the debug port.
  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  localparam int                    LOSS_CNT_W   = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/nios_bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit; q is the last stage.
module nios_bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_pipe;

  // Shift the raw input through the chain; async clear so the sampled value
  // reads as low during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[STAGES-2:0], d};
  end

  assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/nios_sdram_reset_sequencer.sv
// Turns the asynchronous PLL lock into a debounced, synchronously released
// system/SDRAM reset with an SDRAM power-up hold, plus a lock-loss counter.
module nios_sdram_reset_sequencer
  import nios_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 5000,
  parameter int CNT_W              = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  reset_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]            state_o
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             locked_sync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             reset_nxt, ready_nxt, loss_inc;

  nios_bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_sync)
  );

  // State, phase counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RESET;
      cnt       <= '0;
      reset_out <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      reset_out <= reset_nxt;
      ready     <= ready_nxt;
    end
  end

  // Next state and counter. Lock loss beats sw request; the counter is
  // cleared on every state change so each phase starts from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      ST_RESET:     state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (locked_sync) state_nxt = ST_STABLE;
      ST_STABLE: begin
        if (!locked_sync)             state_nxt = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = ST_HOLD;
        else                          cnt_nxt   = cnt + CNT_ONE;
      end
      ST_HOLD: begin
        if (!locked_sync)           state_nxt = ST_WAIT_LOCK;
        else if (sw_reset_req)      cnt_nxt   = '0;
        else if (cnt == HOLD_LAST)  state_nxt = ST_RUN;
        else                        cnt_nxt   = cnt + CNT_ONE;
      end
      ST_RUN: begin
        if (!locked_sync)       state_nxt = ST_WAIT_LOCK;
        else if (sw_reset_req)  state_nxt = ST_HOLD;
      end
      default:                  state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // Output decode from the next state so the registered outputs track RUN
  // on the same edge as the state register.
  always_comb begin
    reset_nxt = (state_nxt != ST_RUN);
    ready_nxt = (state_nxt == ST_RUN);
    loss_inc  = (state == ST_RUN) && !locked_sync;
  end

  // Saturating lock-loss event counter; only losses seen while running count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          lock_loss_cnt <= '0;
    else if (loss_inc && lock_loss_cnt != LOSS_CNT_MAX) lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
  end

  assign state_o = state;

endmodule

// File: tb/tb_nios_sdram_reset_sequencer.sv
// Bench for the reset sequencer: expectations are scheduled against an edge
// count when stimulus is applied and compared on the falling clock edge.
module tb_nios_sdram_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       reset_out;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] loss_exp = 8'd0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [2:0] st;
    logic [7:0] loss;
  } exp_t;

  exp_t sb[$];

  nios_sdram_reset_sequencer #(
    .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .sw_reset_req  (sw_reset_req),
    .reset_out     (reset_out),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Schedule an expectation for the state after edge c; outputs follow state.
  function automatic void push(input int c, input string tag, input logic [2:0] st,
                               input logic [7:0] loss);
    exp_t e;
    int   i;
    e.cyc = c; e.tag = tag; e.st = st; e.loss = loss;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endfunction

  // Compare every expectation that falls due after the latest edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_state"}, state_o, e.st);
      chk({e.tag, "_rst"},   reset_out, (e.st != 3'd4));
      chk({e.tag, "_rdy"},   ready, (e.st == 3'd4));
      chk({e.tag, "_loss"},  lock_loss_cnt, e.loss);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  // Raise lock from WAIT_LOCK and follow it through to RUN (e0 = next edge).
  task automatic do_lock(input string tag);
    int e0;
    pll_locked = 1'b1;
    e0 = cyc + 1;
    push(e0 + 1,  {tag, "_sync"},   3'd1, loss_exp);
    push(e0 + 2,  {tag, "_stable"}, 3'd2, loss_exp);
    push(e0 + 5,  {tag, "_stl"},    3'd2, loss_exp);
    push(e0 + 6,  {tag, "_hold"},   3'd3, loss_exp);
    push(e0 + 13, {tag, "_hl"},     3'd3, loss_exp);
    push(e0 + 14, {tag, "_run"},    3'd4, loss_exp);
    wait_cyc(15);
  endtask

  // Drop lock while running; reset reasserts one edge after locked_sync falls.
  task automatic do_loss();
    int c0;
    c0 = cyc;
    pll_locked = 1'b0;
    push(c0 + 2, "loss_pre", 3'd4, loss_exp);
    loss_exp = sat_inc(loss_exp);
    push(c0 + 3, "loss_hit", 3'd1, loss_exp);
    wait_cyc(3);
  endtask

  initial begin
    int c0;
    int c1;
    rst = 1'b1; pll_locked = 1'b0; sw_reset_req = 1'b0;

    // Power-up: held in reset, then one edge to WAIT_LOCK and stay there.
    for (int i = 1; i <= 5; i++) push(i, "pwr_rst", 3'd0, 8'd0);
    wait_cyc(5);
    rst = 1'b0;
    push(cyc + 1, "pwr_wait", 3'd1, 8'd0);
    push(cyc + 4, "pwr_stay", 3'd1, 8'd0);
    wait_cyc(4);

    // Clean lock: release exactly 14 edges after e0.
    do_lock("lock");

    // sw request in RUN: HOLD next edge, release 8 edges later.
    c0 = cyc;
    sw_reset_req = 1'b1;
    push(c0 + 1, "sw_hold", 3'd3, loss_exp);
    push(c0 + 8, "sw_hl",   3'd3, loss_exp);
    push(c0 + 9, "sw_run",  3'd4, loss_exp);
    wait_cyc(1); sw_reset_req = 1'b0;
    wait_cyc(8);

    // Second request at HOLD counter 5 restarts the hold.
    c0 = cyc;
    sw_reset_req = 1'b1;
    push(c0 + 1, "sw2_hold", 3'd3, loss_exp);
    wait_cyc(1); sw_reset_req = 1'b0;
    wait_cyc(5);
    sw_reset_req = 1'b1;
    push(c0 + 9,  "sw2_ext", 3'd3, loss_exp);
    push(c0 + 14, "sw2_hl",  3'd3, loss_exp);
    push(c0 + 15, "sw2_run", 3'd4, loss_exp);
    wait_cyc(1); sw_reset_req = 1'b0;
    wait_cyc(8);

    // Simultaneous lock drop and sw request: lock loss wins and counts.
    c0 = cyc;
    pll_locked = 1'b0;
    push(c0 + 2, "sim_pre", 3'd4, loss_exp);
    wait_cyc(2);
    sw_reset_req = 1'b1;
    loss_exp = sat_inc(loss_exp);
    push(c0 + 3, "sim_wait", 3'd1, loss_exp);
    wait_cyc(1); sw_reset_req = 1'b0;
    push(c0 + 5, "sim_stay", 3'd1, loss_exp);
    wait_cyc(2);

    // Glitch during debounce at counter 2: back to WAIT_LOCK, full delay restarts.
    c0 = cyc;
    pll_locked = 1'b1;
    push(c0 + 3, "gl_stable", 3'd2, loss_exp);
    wait_cyc(3);
    pll_locked = 1'b0;
    push(c0 + 5, "gl_cnt2", 3'd2, loss_exp);
    push(c0 + 6, "gl_wait", 3'd1, loss_exp);
    wait_cyc(3);
    push(cyc + 9, "gl_no_early", 3'd3, loss_exp);
    do_lock("gl_relock");

    // Repeated lock loss: counter climbs to 255 and saturates.
    for (int i = 0; i < 256; i++) begin
      do_loss();
      do_lock("rl");
    end

    // Async reset in the middle of HOLD clears everything before any edge.
    c0 = cyc;
    sw_reset_req = 1'b1;
    push(c0 + 1, "ar_hold", 3'd3, loss_exp);
    wait_cyc(1); sw_reset_req = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    #1;
    chk("ar_now_state", state_o, 3'd0);
    chk("ar_now_rst",   reset_out, 1'b1);
    chk("ar_now_rdy",   ready, 1'b0);
    chk("ar_now_loss",  lock_loss_cnt, 8'd0);
    loss_exp = 8'd0;
    push(cyc + 1, "ar_held", 3'd0, 8'd0);
    wait_cyc(2);
    rst = 1'b0;
    c1 = cyc;
    push(c1 + 1,  "ar_wait", 3'd1, 8'd0);
    push(c1 + 14, "ar_hl",   3'd3, 8'd0);
    push(c1 + 15, "ar_run",  3'd4, 8'd0);
    wait_cyc(16);

    wait_cyc(2);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
